// File: rtl/data_sync_capture_en_pulse_gen.sv
// Enable synchronizer chain and rising-edge detector for the CLK domain.
// cap is a pure AND of two flop outputs, so it is ready early in the cycle.
module en_pulse_gen #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic BUS_EN,
  output logic cap
);

  logic [NUM_STAGES-1:0] en_ff;
  logic                  en_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      en_ff <= '0;
      en_q  <= 1'b0;
    end else begin
      en_ff <= {en_ff[NUM_STAGES-2:0], BUS_EN};
      en_q  <= en_ff[NUM_STAGES-1];
    end
  end

  // Rising edge only; a falling enable never produces a strobe.
  assign cap = en_ff[NUM_STAGES-1] & ~en_q;

endmodule

// File: rtl/data_sync_capture.sv
// Destination-domain capture of a quasi-static bus qualified by a synchronized enable,
// with a valid/ack hand-off and a sticky, saturating overrun record.
module data_sync_capture #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_EN,
  input  logic                 SYNC_ACK,
  input  logic                 OVR_CLR,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 SYNC_VALID,
  output logic                 OVERRUN,
  output logic [CNT_WIDTH-1:0] OVR_CNT
);

  localparam logic [0:0]           IDLE    = 1'b0;
  localparam logic [0:0]           FULL    = 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic cap;
  logic ovr_ev;

  en_pulse_gen #(.NUM_STAGES(NUM_STAGES)) u_en_pulse_gen (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .BUS_EN (BUS_EN),
    .cap    (cap)
  );

  // An ack on the capture edge means the old word was consumed, so no overrun.
  assign ovr_ev = cap & (SYNC_VALID == FULL) & ~SYNC_ACK;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      SYNC_BUS     <= '0;
      ENABLE_PULSE <= 1'b0;
    end else begin
      ENABLE_PULSE <= cap;
      if (cap) SYNC_BUS <= UNSYNC_BUS;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)
      SYNC_VALID <= IDLE;
    else if (cap)
      SYNC_VALID <= FULL;
    else if (SYNC_ACK)
      SYNC_VALID <= IDLE;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      OVERRUN <= 1'b0;
      OVR_CNT <= '0;
    end else if (ovr_ev) begin
      OVERRUN <= 1'b1;
      if (OVR_CLR)
        OVR_CNT <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      else if (OVR_CNT != CNT_MAX)
        OVR_CNT <= OVR_CNT + 1'b1;
    end else if (OVR_CLR) begin
      OVERRUN <= 1'b0;
      OVR_CNT <= '0;
    end
  end

endmodule

// File: tb/tb_data_sync_capture.sv
// Randomized and directed bench for data_sync_capture against a history-based reference model.
module tb_data_sync_capture;

  localparam int NS = 2;
  localparam int BW = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic [BW-1:0] UNSYNC_BUS = '0;
  logic          BUS_EN = 1'b0;
  logic          SYNC_ACK = 1'b0;
  logic          OVR_CLR = 1'b0;
  logic [BW-1:0] SYNC_BUS;
  logic          ENABLE_PULSE;
  logic          SYNC_VALID;
  logic          OVERRUN;
  logic [CW-1:0] OVR_CNT;

  data_sync_capture #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST_n(RST_n), .UNSYNC_BUS(UNSYNC_BUS), .BUS_EN(BUS_EN),
    .SYNC_ACK(SYNC_ACK), .OVR_CLR(OVR_CLR), .SYNC_BUS(SYNC_BUS),
    .ENABLE_PULSE(ENABLE_PULSE), .SYNC_VALID(SYNC_VALID), .OVERRUN(OVERRUN),
    .OVR_CNT(OVR_CNT)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = -1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: BUS_EN samples recorded per edge since reset (bit 0 newest).
  // A capture happens on the edge NS edges after a 0->1 change between consecutive samples.
  logic [15:0]   hist;
  logic [BW-1:0] m_bus;
  logic          m_pulse, m_valid, m_ovr;
  int            m_cnt;
  logic          m_cap;
  logic          m_ev;
  assign m_cap = hist[NS-1] & ~hist[NS];
  assign m_ev  = m_cap & m_valid & ~SYNC_ACK;

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      hist <= '0; m_bus <= '0; m_pulse <= 1'b0; m_valid <= 1'b0; m_ovr <= 1'b0; m_cnt <= 0;
    end else begin
      hist    <= {hist[14:0], BUS_EN};
      m_pulse <= m_cap;
      if (m_cap) m_bus <= UNSYNC_BUS;
      m_valid <= m_cap ? 1'b1 : (SYNC_ACK ? 1'b0 : m_valid);
      if (m_ev) begin
        m_ovr <= 1'b1;
        m_cnt <= OVR_CLR ? 1 : ((m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1);
      end else if (OVR_CLR) begin
        m_ovr <= 1'b0;
        m_cnt <= 0;
      end
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Compare process plus pulse monitor.
  always @(negedge CLK) begin
    check("SYNC_BUS", int'(SYNC_BUS), int'(m_bus));
    check("ENABLE_PULSE", int'(ENABLE_PULSE), int'(m_pulse));
    check("SYNC_VALID", int'(SYNC_VALID), int'(m_valid));
    check("OVERRUN", int'(OVERRUN), int'(m_ovr));
    check("OVR_CNT", int'(OVR_CNT), m_cnt);
    if (ENABLE_PULSE) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One transfer: enable high for hold cycles, then low long enough to re-arm.
  task automatic xfer(input logic [BW-1:0] d, input int hold);
    UNSYNC_BUS = d;
    BUS_EN = 1'b1;
    cycles(hold);
    BUS_EN = 1'b0;
    cycles(NS + 2);
  endtask

  int c0, p0;

  initial begin
    cycles(3);
    check("reset SYNC_BUS", int'(SYNC_BUS), 0);
    check("reset SYNC_VALID", int'(SYNC_VALID), 0);
    check("reset OVR_CNT", int'(OVR_CNT), 0);
    RST_n = 1'b1;
    cycles(2);

    // 1: single capture with enable held
    p0 = pulse_cnt;
    c0 = cyc;
    UNSYNC_BUS = 8'hA5;
    BUS_EN = 1'b1;
    cycles(10);
    check("t1 pulse count", pulse_cnt - p0, 1);
    check("t1 pulse latency", last_pulse_cyc - c0, NS + 1);
    check("t1 SYNC_BUS", int'(SYNC_BUS), 8'hA5);
    check("t1 SYNC_VALID", int'(SYNC_VALID), 1);
    check("t1 OVERRUN", int'(OVERRUN), 0);
    BUS_EN = 1'b0;
    cycles(NS + 2);

    // 2: ack empties the register but keeps the data
    SYNC_ACK = 1'b1;
    cycles(1);
    SYNC_ACK = 1'b0;
    cycles(1);
    check("t2 SYNC_VALID", int'(SYNC_VALID), 0);
    check("t2 SYNC_BUS", int'(SYNC_BUS), 8'hA5);

    // 3: back-to-back transfers without ack, then saturation
    xfer(8'h11, 4);
    xfer(8'h22, 4);
    check("t3 SYNC_BUS", int'(SYNC_BUS), 8'h22);
    check("t3 OVERRUN", int'(OVERRUN), 1);
    check("t3 OVR_CNT", int'(OVR_CNT), 1);
    for (int i = 0; i < 19; i++) xfer(8'(i + 8'h30), 3);
    check("t3 OVR_CNT sat", int'(OVR_CNT), 15);

    // 4: clear, then capture coinciding with ack, then clear racing an overrun
    OVR_CLR = 1'b1;
    cycles(1);
    OVR_CLR = 1'b0;
    check("t4 cleared cnt", int'(OVR_CNT), 0);
    UNSYNC_BUS = 8'h5A;
    BUS_EN = 1'b1;
    cycles(NS);
    SYNC_ACK = 1'b1;
    cycles(1);
    SYNC_ACK = 1'b0;
    check("t4 ack+cap valid", int'(SYNC_VALID), 1);
    check("t4 ack+cap ovr", int'(OVERRUN), 0);
    check("t4 ack+cap bus", int'(SYNC_BUS), 8'h5A);
    BUS_EN = 1'b0;
    cycles(NS + 2);
    xfer(8'h66, 3);
    check("t4 cnt before clr", int'(OVR_CNT), 1);
    UNSYNC_BUS = 8'h77;
    BUS_EN = 1'b1;
    cycles(NS);
    OVR_CLR = 1'b1;
    cycles(1);
    OVR_CLR = 1'b0;
    check("t4 clr vs ovr cnt", int'(OVR_CNT), 1);
    check("t4 clr vs ovr flag", int'(OVERRUN), 1);
    BUS_EN = 1'b0;
    cycles(NS + 2);

    // 5: async reset with a 1 in the chain, release with enable still high
    UNSYNC_BUS = 8'hC3;
    BUS_EN = 1'b1;
    @(posedge CLK);
    #2 RST_n = 1'b0;
    #1;
    check("t5 async SYNC_BUS", int'(SYNC_BUS), 0);
    check("t5 async SYNC_VALID", int'(SYNC_VALID), 0);
    check("t5 async OVERRUN", int'(OVERRUN), 0);
    check("t5 async OVR_CNT", int'(OVR_CNT), 0);
    cycles(2);
    p0 = pulse_cnt;
    RST_n = 1'b1;
    cycles(8);
    check("t5 one capture", pulse_cnt - p0, 1);
    check("t5 SYNC_BUS", int'(SYNC_BUS), 8'hC3);
    BUS_EN = 1'b0;
    cycles(NS + 2);

    // 6: glitch between edges is never sampled; re-arm after 3 low cycles
    p0 = pulse_cnt;
    #2 BUS_EN = 1'b1;
    #2 BUS_EN = 1'b0;
    cycles(6);
    check("t6 glitch", pulse_cnt - p0, 0);
    UNSYNC_BUS = 8'h3C;
    BUS_EN = 1'b1;
    cycles(3);
    BUS_EN = 1'b0;
    cycles(3);
    UNSYNC_BUS = 8'hE7;
    BUS_EN = 1'b1;
    cycles(NS + 3);
    check("t6 two captures", pulse_cnt - p0, 2);
    check("t6 SYNC_BUS", int'(SYNC_BUS), 8'hE7);
    BUS_EN = 1'b0;
    cycles(NS + 2);

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) BUS_EN = ~BUS_EN;
      UNSYNC_BUS = BW'($urandom);
      SYNC_ACK   = ($urandom_range(0, 2) == 0);
      OVR_CLR    = ($urandom_range(0, 15) == 0);
      cycles(1);
    end
    BUS_EN = 1'b0; SYNC_ACK = 1'b0; OVR_CLR = 1'b0;
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
